frame_reader_mb: RTL and testbench
==================================

# frame_reader_mb

Parametrised, multi-buffer successor to the LCD frame reader. Streams a frame buffer from SDRAM into the pixel FIFO in fixed-length read bursts, keeping the FIFO between a low and high watermark by hysteresis. Selects one of two frame buffers at each frame boundary, giving tear-free page flipping. Sits between the SDRAM arbiter/controller and the pixel FIFO feeding the LCD timing generator.

## Interface
- ADDR_W, 22: SDRAM word address width.
- USED_W, 11: width of the FIFO fill count; must represent FIFO_DEPTH.
- FIFO_DEPTH, 1024: pixel FIFO capacity in words.
- BURST_LEN, 8: words per read burst; 1..256.
- LOW_WM, 256: refill starts when fill count <= LOW_WM.
- FRAME_WORDS, 96000: words per frame (480*200); must be a multiple of BURST_LEN.
- BUF0_BASE, 0: word address of buffer 0.
- BUF1_BASE, 96000: word address of buffer 1.
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Begin  in  1  enable streaming; level.
- i_Buffer_Sel  in  1  requested display buffer; sampled only at frame boundaries.
- i_Data_Read_Valid  in  1  SDRAM read beat valid.
- i_Pixel_In_Used  in  USED_W  current pixel FIFO fill count.
- i_SDRAM_Grant  in  1  arbiter grant.
- o_Command  out  2  CMD_IDLE or CMD_READ, using the sdram.vh encodings.
- o_Data_Address  out  ADDR_W  address of the next word to read.
- o_FIFO_Wr  out  1  FIFO write strobe.
- o_SDRAM_Request  out  1  bus request to the arbiter.
- o_First_Data_Ready  out  1  at least one burst has landed since enable.
- o_Frame_Start  out  1  one-cycle pulse when the frame offset wraps to 0.
- o_Active_Buffer  out  1  buffer currently being read.

## Operation
- Reset values: o_Command=CMD_IDLE; offset=0; o_Active_Buffer=0; o_Data_Address=BUF0_BASE; filling=0; o_First_Data_Ready=0; o_Frame_Start=0; FSM in IDLE.
- Watermarks:
  - low = (used <= LOW_WM).
  - high = (used >= FIFO_DEPTH-BURST_LEN).
  - need = (low & !filling) | (filling & !high).
- filling:
  - Set on each burst start.
  - Cleared on any cycle where filling & high.
  - A clear and a set in the same cycle resolve to set.
- FSM states:
  - IDLE -> READ when i_Begin & i_SDRAM_Grant & need. Load countdown = BURST_LEN-1; o_Command=CMD_READ.
  - READ: on each i_Data_Read_Valid, decrement countdown and advance the address. On the beat with countdown==0 -> IDLE, o_Command=CMD_IDLE, and set o_First_Data_Ready.
  - READ -> DRAIN when i_Begin falls mid-burst. DRAIN behaves as READ (a burst is never aborted) but exits to IDLE and performs the disable actions below.
- Disable actions, applied when i_Begin=0 in IDLE, or at DRAIN exit:
  - Clear o_First_Data_Ready and filling.
  - offset=0.
  - o_Active_Buffer=i_Buffer_Sel.
  - Address = selected base.
- o_FIFO_Wr = (o_Command==CMD_READ) & i_Data_Read_Valid, combinational. Beats with o_Command==CMD_IDLE are ignored.
- o_SDRAM_Request = (i_Begin & need) | (o_Command!=CMD_IDLE), combinational. It is held high for the whole burst.
- Address arithmetic:
  - offset is an ADDR_W-bit counter in 0..FRAME_WORDS-1.
  - o_Data_Address = base(o_Active_Buffer) + offset, registered and updated in the same edge as offset.
  - On a beat with offset==FRAME_WORDS-1: offset becomes 0, o_Active_Buffer latches i_Buffer_Sel, and o_Frame_Start pulses on the following cycle.
  - i_Buffer_Sel changes at any other time have no effect.

## Timing
- A grant in cycle N (IDLE, need true) gives o_Command=CMD_READ in N+1. There is no minimum number of grant cycles.
- Each valid beat produces o_FIFO_Wr in the same cycle and an address increment at the following edge.
- The last beat of a burst returns o_Command to CMD_IDLE in the next cycle. A new burst can start one cycle after that (at least one IDLE cycle between bursts).
- o_Frame_Start is high for exactly one cycle, the cycle after the wrapping beat.
- Asserting i_Rst_n low mid-burst forces all reset values immediately, without waiting for a clock.
- Gaps between valid beats are allowed. The countdown holds during gaps.

## Test plan
- Reset and start: i_Rst_n low, then high; i_Begin=1; used=0; grant held high. Required: 8 o_FIFO_Wr pulses; address goes 0..8; o_First_Data_Ready rises after beat 8; next burst starts after 1 idle cycle.
- Hysteresis:
  - used=1016: request stays asserted while filling. Filling clears; request drops.
  - used falls to 300: no request.
  - used falls to 256: request rises.
- Frame wrap with flip: offset=95992, i_Buffer_Sel=1, then one burst. Required: addresses 95992..95999, then 96000 (BUF1_BASE+0); o_Frame_Start 1-cycle pulse; o_Active_Buffer=1.
- Mid-frame select ignored: toggle i_Buffer_Sel at offset 5000. Required: o_Active_Buffer unchanged until the wrap.
- Disable mid-burst: drop i_Begin after beat 3 of 8. Required: all 8 beats still written; then IDLE; o_First_Data_Ready=0; address=selected base; no further requests.
- Async reset mid-burst: assert i_Rst_n low between clock edges at beat 5. Required: o_Command=CMD_IDLE and address=BUF0_BASE immediately; o_FIFO_Wr=0 even with i_Data_Read_Valid high.

Source files
------------

// File: rtl/frame_reader_mb.sv
// Frame reader: streams a double-buffered frame from SDRAM into the pixel FIFO in
// fixed-length bursts, refilling by watermark hysteresis and flipping buffers only at frame wrap.
module frame_reader_mb #(
  parameter int ADDR_W      = 22,
  parameter int USED_W      = 11,
  parameter int FIFO_DEPTH  = 1024,
  parameter int BURST_LEN   = 8,
  parameter int LOW_WM      = 256,
  parameter int FRAME_WORDS = 96000,
  parameter int BUF0_BASE   = 0,
  parameter int BUF1_BASE   = 96000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Begin,
  input  logic              i_Buffer_Sel,
  input  logic              i_Data_Read_Valid,
  input  logic [USED_W-1:0] i_Pixel_In_Used,
  input  logic              i_SDRAM_Grant,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic              o_FIFO_Wr,
  output logic              o_SDRAM_Request,
  output logic              o_First_Data_Ready,
  output logic              o_Frame_Start,
  output logic              o_Active_Buffer
);

  localparam logic [1:0]        CMD_IDLE  = 2'b00;
  localparam logic [1:0]        CMD_READ  = 2'b01;
  localparam logic [USED_W-1:0] LOW_U     = USED_W'(LOW_WM);
  localparam logic [USED_W-1:0] HIGH_U    = USED_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(BUF0_BASE);
  localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(BUF1_BASE);
  localparam logic [ADDR_W-1:0] LAST_OFF  = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [7:0]        BURST_CNT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [7:0]        count_q, count_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              active_q, active_d;
  logic              filling_q, filling_d;
  logic              first_q, first_d;
  logic              frame_start_q, frame_start_d;

  logic low, high, need, beat, disable_now;

  function automatic logic [ADDR_W-1:0] base_of(input logic sel);
    return sel ? BASE1 : BASE0;
  endfunction

  assign low  = (i_Pixel_In_Used <= LOW_U);
  assign high = (i_Pixel_In_Used >= HIGH_U);
  assign need = (low & ~filling_q) | (filling_q & ~high);
  // Beats arriving while no read is outstanding belong to someone else.
  assign beat = (cmd_q == CMD_READ) & i_Data_Read_Valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cmd_d         = cmd_q;
    count_d       = count_q;
    offset_d      = offset_q;
    addr_d        = addr_q;
    active_d      = active_q;
    filling_d     = filling_q;
    first_d       = first_q;
    frame_start_d = 1'b0;
    disable_now   = 1'b0;

    if (filling_q && high) filling_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!i_Begin) begin
          disable_now = 1'b1;
        end else if (i_SDRAM_Grant && need) begin
          state_d   = ST_READ;
          cmd_d     = CMD_READ;
          count_d   = BURST_CNT;
          filling_d = 1'b1;
        end
      end
      ST_READ, ST_DRAIN: begin
        if (state_q == ST_READ && !i_Begin) state_d = ST_DRAIN;
        if (beat) begin
          count_d = count_q - 8'd1;
          if (offset_q == LAST_OFF) begin
            offset_d      = '0;
            active_d      = i_Buffer_Sel;
            frame_start_d = 1'b1;
          end else begin
            offset_d = offset_q + ADDR_W'(1);
          end
          addr_d = base_of(active_d) + offset_d;
          if (count_q == 8'd0) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_IDLE;
            if (state_q == ST_DRAIN) disable_now = 1'b1;
            else                     first_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabled: rewind to the start of whichever buffer is requested now.
    if (disable_now) begin
      first_d   = 1'b0;
      filling_d = 1'b0;
      offset_d  = '0;
      active_d  = i_Buffer_Sel;
      addr_d    = base_of(i_Buffer_Sel);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_IDLE;
      count_q       <= '0;
      offset_q      <= '0;
      addr_q        <= BASE0;
      active_q      <= 1'b0;
      filling_q     <= 1'b0;
      first_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      count_q       <= count_d;
      offset_q      <= offset_d;
      addr_q        <= addr_d;
      active_q      <= active_d;
      filling_q     <= filling_d;
      first_q       <= first_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Command          = cmd_q;
  assign o_Data_Address     = addr_q;
  assign o_FIFO_Wr          = beat;
  assign o_SDRAM_Request    = (i_Begin & need) | (cmd_q != CMD_IDLE);
  assign o_First_Data_Ready = first_q;
  assign o_Frame_Start      = frame_start_q;
  assign o_Active_Buffer    = active_q;

endmodule

// File: tb/tb_frame_reader_mb.sv
// Bench for frame_reader_mb: a reduced frame size keeps the wrap reachable; beat addresses are
// predicted by a small model, queued at drive time and compared when o_FIFO_Wr is seen.
module tb_frame_reader_mb;

  localparam int ADDR_W = 22;
  localparam int USED_W = 11;
  localparam int BL     = 8;
  localparam int FW     = 64;
  localparam int B0     = 0;
  localparam int B1     = 1000;
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              begin_r;
  logic              sel;
  logic              valid;
  logic [USED_W-1:0] used;
  logic              grant;
  logic [1:0]        o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic              o_FIFO_Wr, o_SDRAM_Request, o_First_Data_Ready, o_Frame_Start, o_Active_Buffer;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          exp_off = 0;
  logic        exp_buf = 1'b0;
  logic        dropped = 1'b0;

  frame_reader_mb #(
    .ADDR_W(ADDR_W), .USED_W(USED_W), .FIFO_DEPTH(1024), .BURST_LEN(BL), .LOW_WM(256),
    .FRAME_WORDS(FW), .BUF0_BASE(B0), .BUF1_BASE(B1)
  ) dut (
    .i_Clk              (clk),
    .i_Rst_n            (rst_n),
    .i_Begin            (begin_r),
    .i_Buffer_Sel       (sel),
    .i_Data_Read_Valid  (valid),
    .i_Pixel_In_Used    (used),
    .i_SDRAM_Grant      (grant),
    .o_Command          (o_Command),
    .o_Data_Address     (o_Data_Address),
    .o_FIFO_Wr          (o_FIFO_Wr),
    .o_SDRAM_Request    (o_SDRAM_Request),
    .o_First_Data_Ready (o_First_Data_Ready),
    .o_Frame_Start      (o_Frame_Start),
    .o_Active_Buffer    (o_Active_Buffer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_addr();
    return 32'((exp_buf ? B1 : B0) + exp_off);
  endfunction

  // Scoreboard side: every FIFO write must match the oldest predicted address.
  always @(negedge clk) begin
    if (rst_n && o_FIFO_Wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(o_Data_Address), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat_addr", 32'(o_Data_Address), mon_exp);
      end
    end
  end

  task automatic wait_read();
    int n = 0;
    while (o_Command != CMD_READ && n < 50) begin
      tick();
      n++;
    end
    check("wait_read", 32'(o_Command), 32'(CMD_READ));
  endtask

  task automatic do_beats(input int n_beats, input int gap, input int drop_after);
    logic fs;
    dropped = 1'b0;
    for (int i = 1; i <= n_beats; i++) begin
      check("cmd_in_burst", 32'(o_Command), 32'(CMD_READ));
      check("req_in_burst", 32'(o_SDRAM_Request), 32'd1);
      exp_q.push_back(model_addr());
      fs = 1'b0;
      if (exp_off == FW - 1) begin
        exp_off = 0;
        exp_buf = sel;
        fs      = 1'b1;
      end else begin
        exp_off++;
      end
      valid = 1'b1;
      tick();
      valid = 1'b0;
      if (dropped && i == BL) begin
        exp_off = 0;
        exp_buf = sel;
      end
      check("frame_start", 32'(o_Frame_Start), 32'(fs));
      check("active_buf", 32'(o_Active_Buffer), 32'(exp_buf));
      if (i == drop_after) begin
        begin_r = 1'b0;
        dropped = 1'b1;
      end
      for (int g = 0; g < gap && i < n_beats; g++) begin
        tick();
        check("frame_start_gap", 32'(o_Frame_Start), 32'd0);
      end
    end
    if (n_beats == BL) begin
      check("cmd_after_burst", 32'(o_Command), 32'(CMD_IDLE));
      check("first_ready", 32'(o_First_Data_Ready), 32'(!dropped));
      check("addr_after_burst", 32'(o_Data_Address), model_addr());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; begin_r = 1'b0; sel = 1'b0; valid = 1'b0; used = '0; grant = 1'b0;
    repeat (2) tick();
    check("rst_cmd", 32'(o_Command), 32'(CMD_IDLE));
    check("rst_addr", 32'(o_Data_Address), 32'(B0));
    check("rst_first", 32'(o_First_Data_Ready), 32'd0);
    check("rst_fs", 32'(o_Frame_Start), 32'd0);
    check("rst_active", 32'(o_Active_Buffer), 32'd0);
    check("rst_req", 32'(o_SDRAM_Request), 32'd0);

    // Burst 1 from reset, then exactly one idle cycle before burst 2.
    rst_n = 1'b1; begin_r = 1'b1; grant = 1'b1;
    wait_read();
    check("first_before", 32'(o_First_Data_Ready), 32'd0);
    check("addr_start", 32'(o_Data_Address), 32'(B0));
    do_beats(BL, 0, 0);
    tick();
    check("one_idle_gap", 32'(o_Command), 32'(CMD_READ));

    // Burst 2 with a gap between every beat.
    wait_read();
    do_beats(BL, 1, 0);

    // Burst 3: FIFO hits the high mark mid-burst; hysteresis then holds off refill.
    wait_read();
    used = 11'd1016;
    do_beats(BL, 0, 0);
    check("hi_req_drop", 32'(o_SDRAM_Request), 32'd0);
    repeat (3) tick();
    check("hi_stay_idle", 32'(o_Command), 32'(CMD_IDLE));
    used = 11'd300;
    #1;
    check("mid_no_req", 32'(o_SDRAM_Request), 32'd0);
    repeat (3) tick();
    check("mid_stay_idle", 32'(o_Command), 32'(CMD_IDLE));
    used = 11'd256;
    #1;
    check("low_req", 32'(o_SDRAM_Request), 32'd1);
    used = '0;

    // Bursts 4..8: select toggles mid-frame are ignored; the wrap picks up sel=1.
    for (int b = 0; b < 5; b++) begin
      sel = b[0] ? 1'b0 : 1'b1;
      wait_read();
      do_beats(BL, 0, 0);
    end
    wait_read();
    check("fs_one_cycle", 32'(o_Frame_Start), 32'd0);
    check("addr_buf1", 32'(o_Data_Address), 32'(B1));
    do_beats(BL, 0, 0);

    // Burst 10: drop enable after beat 3; burst completes, then rewinds to buffer 0.
    sel = 1'b0;
    wait_read();
    do_beats(BL, 0, 3);
    repeat (4) begin
      tick();
      check("dis_no_req", 32'(o_SDRAM_Request), 32'd0);
    end
    check("dis_idle", 32'(o_Command), 32'(CMD_IDLE));
    check("dis_addr", 32'(o_Data_Address), 32'(B0));

    // Re-enable, one burst, then asynchronous reset during beat 5 of the next.
    begin_r = 1'b1;
    wait_read();
    do_beats(BL, 0, 0);
    wait_read();
    do_beats(4, 0, 0);
    valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cmd", 32'(o_Command), 32'(CMD_IDLE));
    check("arst_addr", 32'(o_Data_Address), 32'(B0));
    check("arst_wr", 32'(o_FIFO_Wr), 32'd0);
    check("arst_first", 32'(o_First_Data_Ready), 32'd0);
    valid = 1'b0; begin_r = 1'b0;
    exp_off = 0; exp_buf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
